// File: rtl/chip8_pkg.sv
// Shared sizes, write-protection limit and requester IDs for the CHIP-8 memory arbiter.
package chip8_pkg;

    localparam int N_REQ    = 3;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 8;
    localparam int LOCK_MAX = 16;

    localparam logic [ADDR_W-1:0] PROT_LIMIT = 12'h200;

    localparam int REQ_FETCH = 0;
    localparam int REQ_CPU   = 1;
    localparam int REQ_SPR   = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority single grant; a valid owner masks every other requester.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          own_vld_i,
    input  logic [PW-1:0] own_id_i,
    output logic [N-1:0]  gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        if (own_vld_i) begin
            if (req_i[own_id_i]) gnt_o[own_id_i] = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = PW'((int'(ptr_i) + k) % N);
                if (!found && req_i[idx]) begin
                    gnt_o[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Arbitrates the single-port CHIP-8 memory between fetch, CPU data and sprite requesters,
// with bus lock, protected-region write drop and a 2-stage read response pipeline.
module chip8_mem_arbiter
    import chip8_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ-1:0]          we_i,
    input  logic [N_REQ-1:0]          lock_i,
    input  logic [N_REQ*ADDR_W-1:0]   addr_i,
    input  logic [N_REQ*DATA_W-1:0]   wdata_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      wr_err_o,
    output logic                      lock_abort_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic                      mem_we_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              own_vld_q, own_vld_d;
    logic [PW-1:0]     own_id_q, own_id_d;
    logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              wr_err_q, wr_err_d;
    logic              abort_q, abort_d;
    logic              s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [PW-1:0]     s1_id_q, s1_id_d, s2_id_q, s2_id_d;

    logic              hs;
    logic [PW-1:0]     hs_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we, sel_lock, sel_prot;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
        .req_i     (req_i),
        .ptr_i     (rr_ptr_q),
        .own_vld_i (own_vld_q),
        .own_id_i  (own_id_q),
        .gnt_o     (gnt_o)
    );

    always_comb begin
        hs    = |gnt_o;
        hs_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_o[i]) hs_id = PW'(i);
        end
        sel_addr  = addr_i[int'(hs_id)*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[int'(hs_id)*DATA_W +: DATA_W];
        sel_we    = we_i[hs_id];
        sel_lock  = lock_i[hs_id];
        sel_prot  = sel_addr < PROT_LIMIT;

        rr_ptr_d    = rr_ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        wr_err_d    = 1'b0;
        s1_vld_d    = 1'b0;
        s1_id_d     = s1_id_q;
        s2_vld_d    = s1_vld_q;
        s2_id_d     = s1_id_q;
        own_vld_d   = own_vld_q;
        own_id_d    = own_id_q;
        lock_cnt_d  = own_vld_q ? lock_cnt_q + 1'b1 : '0;
        abort_d     = 1'b0;

        if (hs) begin
            rr_ptr_d    = (hs_id == PW'(N_REQ - 1)) ? '0 : hs_id + 1'b1;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_we_d    = sel_we && !sel_prot;
            wr_err_d    = sel_we && sel_prot;
            s1_vld_d    = !sel_we;
            s1_id_d     = hs_id;
            if (sel_lock) begin
                own_vld_d = 1'b1;
                own_id_d  = hs_id;
            end else begin
                own_vld_d  = 1'b0;
                lock_cnt_d = '0;
            end
        end

        // Watchdog only fires if the owner did not release on its own this cycle.
        if (own_vld_q && own_vld_d && lock_cnt_q == CW'(LOCK_MAX - 1)) begin
            own_vld_d  = 1'b0;
            lock_cnt_d = '0;
            abort_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            own_vld_q   <= 1'b0;
            own_id_q    <= '0;
            lock_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            abort_q     <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_id_q     <= '0;
            s2_vld_q    <= 1'b0;
            s2_id_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            own_vld_q   <= own_vld_d;
            own_id_q    <= own_id_d;
            lock_cnt_q  <= lock_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            wr_err_q    <= wr_err_d;
            abort_q     <= abort_d;
            s1_vld_q    <= s1_vld_d;
            s1_id_q     <= s1_id_d;
            s2_vld_q    <= s2_vld_d;
            s2_id_q     <= s2_id_d;
        end
    end

    always_comb begin
        rvalid_o = '0;
        if (s2_vld_q) rvalid_o[s2_id_q] = 1'b1;
        rdata_o = s2_vld_q ? mem_rdata_i : '0;
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign wr_err_o     = wr_err_q;
    assign lock_abort_o = abort_q;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter with a synchronous 4 KiB memory model.
module tb_chip8_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, we, lock, gnt, rvalid;
    logic [35:0] addr;
    logic [23:0] wdata;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic        wr_err, lock_abort, mem_we;
    logic [11:0] mem_addr;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [4096];

    always #5 clk = ~clk;

    chip8_mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .we_i         (we),
        .lock_i       (lock),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .wr_err_o     (wr_err),
        .lock_abort_o (lock_abort),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'(a + 48);
    end

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    typedef struct {
        logic [2:0]  req, we, lock;
        logic [35:0] addr;
        logic [23:0] wdata;
        logic [2:0]  e_gnt, e_rv;
        logic [7:0]  e_rdata;
        logic        e_we, e_err;
    } vec_t;

    vec_t tv[16];

    function automatic vec_t mk(logic [2:0] r, logic [2:0] w, logic [35:0] a, logic [23:0] d,
                                logic [2:0] g, logic [2:0] rv, logic [7:0] rd,
                                logic mw, logic er);
        vec_t v;
        v.req = r; v.we = w; v.lock = 3'b000; v.addr = a; v.wdata = d;
        v.e_gnt = g; v.e_rv = rv; v.e_rdata = rd; v.e_we = mw; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                         input logic [35:0] a, input logic [23:0] d);
        req = r; we = w; lock = l; addr = a; wdata = d;
    endtask

    localparam logic [35:0] A1 = {12'h030, 12'h020, 12'h010};

    initial begin
        rst_n = 1'b0;
        drive(3'b000, 3'b000, 3'b000, '0, '0);

        tv[0]  = mk(3'b111, 3'b000, A1, '0, 3'b001, 3'b000, 8'h00, 1'b0, 1'b0);
        tv[1]  = mk(3'b111, 3'b000, A1, '0, 3'b010, 3'b000, 8'h00, 1'b0, 1'b0);
        tv[2]  = mk(3'b111, 3'b000, A1, '0, 3'b100, 3'b001, 8'h40, 1'b0, 1'b0);
        tv[3]  = mk(3'b111, 3'b000, A1, '0, 3'b001, 3'b010, 8'h50, 1'b0, 1'b0);
        tv[4]  = mk(3'b000, 3'b000, A1, '0, 3'b000, 3'b100, 8'h60, 1'b0, 1'b0);
        tv[5]  = mk(3'b000, 3'b000, A1, '0, 3'b000, 3'b001, 8'h40, 1'b0, 1'b0);
        tv[6]  = mk(3'b000, 3'b000, A1, '0, 3'b000, 3'b000, 8'h00, 1'b0, 1'b0);
        tv[7]  = mk(3'b010, 3'b010, {12'h0, 12'h1FF, 12'h0}, {8'h0, 8'h11, 8'h0},
                    3'b010, 3'b000, 8'h00, 1'b0, 1'b0);
        tv[8]  = mk(3'b010, 3'b010, {12'h0, 12'h200, 12'h0}, {8'h0, 8'hA5, 8'h0},
                    3'b010, 3'b000, 8'h00, 1'b0, 1'b1);
        tv[9]  = mk(3'b000, 3'b000, '0, '0, 3'b000, 3'b000, 8'h00, 1'b1, 1'b0);
        tv[10] = mk(3'b001, 3'b000, {24'h0, 12'h200}, '0, 3'b001, 3'b000, 8'h00, 1'b0, 1'b0);
        tv[11] = mk(3'b000, 3'b000, '0, '0, 3'b000, 3'b000, 8'h00, 1'b0, 1'b0);
        tv[12] = mk(3'b000, 3'b000, '0, '0, 3'b000, 3'b001, 8'hA5, 1'b0, 1'b0);
        tv[13] = mk(3'b001, 3'b000, {24'h0, 12'h1FF}, '0, 3'b001, 3'b000, 8'h00, 1'b0, 1'b0);
        tv[14] = mk(3'b000, 3'b000, '0, '0, 3'b000, 3'b000, 8'h00, 1'b0, 1'b0);
        tv[15] = mk(3'b000, 3'b000, '0, '0, 3'b000, 3'b001, 8'h2F, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset rvalid", 32'(rvalid), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset wr_err", 32'(wr_err), 32'd0);
        chk("reset lock_abort", 32'(lock_abort), 32'd0);
        chk("reset rdata", 32'(rdata), 32'd0);
        tick();
        rst_n = 1'b1;

        // Round-robin reads and protected/unprotected writes with readback
        for (int i = 0; i < 16; i++) begin
            drive(tv[i].req, tv[i].we, tv[i].lock, tv[i].addr, tv[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(tv[i].e_gnt));
            chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(tv[i].e_rv));
            if (tv[i].e_rv != 3'b000)
                chk($sformatf("v%0d rdata", i), 32'(rdata), 32'(tv[i].e_rdata));
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(tv[i].e_we));
            chk($sformatf("v%0d wr_err", i), 32'(wr_err), 32'(tv[i].e_err));
            tick();
        end

        // Requester 1 locks the bus for three writes; 0 and 2 wait, then rr resumes at 2
        drive(3'b111, 3'b010, 3'b010, {12'h060, 12'h300, 12'h050}, {8'h0, 8'h01, 8'h0});
        @(negedge clk); chk("lock s0 gnt", 32'(gnt), 32'b010); tick();
        drive(3'b111, 3'b010, 3'b010, {12'h060, 12'h301, 12'h050}, {8'h0, 8'h02, 8'h0});
        @(negedge clk); chk("lock s1 gnt", 32'(gnt), 32'b010);
        chk("lock s1 mem_we", 32'(mem_we), 32'd1); tick();
        drive(3'b111, 3'b010, 3'b000, {12'h060, 12'h302, 12'h050}, {8'h0, 8'h03, 8'h0});
        @(negedge clk); chk("lock s2 gnt", 32'(gnt), 32'b010); tick();
        drive(3'b101, 3'b000, 3'b000, {12'h060, 12'h000, 12'h050}, '0);
        @(negedge clk); chk("lock s3 gnt", 32'(gnt), 32'b100); tick();
        drive(3'b001, 3'b000, 3'b000, {12'h000, 12'h000, 12'h302}, '0);
        @(negedge clk); chk("lock s4 gnt", 32'(gnt), 32'b001); tick();
        drive(3'b000, 3'b000, 3'b000, '0, '0);
        @(negedge clk); chk("lock s5 rvalid", 32'(rvalid), 32'b100);
        chk("lock s5 rdata", 32'(rdata), 32'h90); tick();
        @(negedge clk); chk("lock s6 rvalid", 32'(rvalid), 32'b001);
        chk("lock s6 rdata", 32'(rdata), 32'h03); tick();

        // Requester 2 locks then goes quiet; watchdog frees the bus after 16 owned cycles
        drive(3'b100, 3'b000, 3'b100, {12'h070, 24'h0}, '0);
        @(negedge clk); chk("abort q0 gnt", 32'(gnt), 32'b100); tick();
        drive(3'b001, 3'b000, 3'b000, '0, '0);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk($sformatf("abort q%0d gnt", c), 32'(gnt), 32'd0);
            chk($sformatf("abort q%0d pulse", c), 32'(lock_abort), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("abort q17 pulse", 32'(lock_abort), 32'd1);
        chk("abort q17 gnt", 32'(gnt), 32'b001);
        tick();
        drive(3'b000, 3'b000, 3'b000, '0, '0);
        @(negedge clk); chk("abort q18 pulse", 32'(lock_abort), 32'd0); tick();
        repeat (2) tick();

        // Single requester streaming across the 12-bit address wrap
        drive(3'b010, 3'b000, 3'b000, {12'h0, 12'hFFE, 12'h0}, '0);
        @(negedge clk); chk("stream t0 gnt", 32'(gnt), 32'b010); tick();
        drive(3'b010, 3'b000, 3'b000, {12'h0, 12'hFFF, 12'h0}, '0);
        @(negedge clk); chk("stream t1 gnt", 32'(gnt), 32'b010);
        chk("stream t1 mem_addr", 32'(mem_addr), 32'hFFE); tick();
        drive(3'b010, 3'b000, 3'b000, {12'h0, 12'h000, 12'h0}, '0);
        @(negedge clk); chk("stream t2 gnt", 32'(gnt), 32'b010);
        chk("stream t2 rvalid", 32'(rvalid), 32'b010);
        chk("stream t2 rdata", 32'(rdata), 32'h2E); tick();
        drive(3'b000, 3'b000, 3'b000, '0, '0);
        @(negedge clk); chk("stream t3 rvalid", 32'(rvalid), 32'b010);
        chk("stream t3 rdata", 32'(rdata), 32'h2F); tick();
        @(negedge clk); chk("stream t4 rvalid", 32'(rvalid), 32'b010);
        chk("stream t4 rdata", 32'(rdata), 32'h30); tick();
        @(negedge clk); chk("stream t5 rvalid", 32'(rvalid), 32'b000); tick();

        // Reset with two reads in flight
        drive(3'b011, 3'b000, 3'b000, {12'h0, 12'h020, 12'h010}, '0);
        @(negedge clk); chk("rst r0 gnt", 32'(gnt), 32'b001); tick();
        drive(3'b010, 3'b000, 3'b000, {12'h0, 12'h020, 12'h010}, '0);
        @(negedge clk); chk("rst r1 gnt", 32'(gnt), 32'b010); tick();
        drive(3'b000, 3'b000, 3'b000, '0, '0);
        #1 chk("rst pre rvalid", 32'(rvalid), 32'b001);
        #1 rst_n = 1'b0;
        #1 chk("rst async rvalid", 32'(rvalid), 32'd0);
        chk("rst async mem_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rst late rvalid %0d", c), 32'(rvalid), 32'd0);
            tick();
        end
        drive(3'b111, 3'b000, 3'b000, A1, '0);
        @(negedge clk); chk("rst first gnt", 32'(gnt), 32'b001); tick();
        drive(3'b000, 3'b000, 3'b000, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
